// File: rtl/ft600_responder_if.sv
// rtl/ft600_responder_if.sv - FT600-style synchronous FIFO bus bundle between bus master and responder
//
// Signals:
//   ft_data_i  [DATA_WIDTH] master -> responder write data (valid while ft_oe_n=1)
//   ft_be_i    [BE_WIDTH]   master -> responder byte enables
//   ft_data_o  [DATA_WIDTH] responder -> master read data (head of read buffer)
//   ft_be_o    [BE_WIDTH]   responder -> master byte enables
//   ft_data_oe              responder drives ft_data_o/ft_be_o when high
//   ft_rxf_n                low: responder has data for the master
//   ft_txe_n                low: responder has room for master writes
//   ft_rd_n, ft_wr_n, ft_oe_n  master strobes, active-low
// Modports: master (bus initiator), slave (responder).
interface ft600_responder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] ft_data_i;
  logic [DATA_WIDTH-1:0] ft_data_o;
  logic                  ft_data_oe;
  logic [BE_WIDTH-1:0]   ft_be_i;
  logic [BE_WIDTH-1:0]   ft_be_o;
  logic                  ft_rxf_n;
  logic                  ft_txe_n;
  logic                  ft_rd_n;
  logic                  ft_wr_n;
  logic                  ft_oe_n;

  modport master (
    output ft_data_i, ft_be_i, ft_rd_n, ft_wr_n, ft_oe_n,
    input  ft_data_o, ft_be_o, ft_data_oe, ft_rxf_n, ft_txe_n
  );

  modport slave (
    input  ft_data_i, ft_be_i, ft_rd_n, ft_wr_n, ft_oe_n,
    output ft_data_o, ft_be_o, ft_data_oe, ft_rxf_n, ft_txe_n
  );
endinterface

// File: rtl/ft600_responder.sv
// rtl/ft600_responder.sv - FT600 bus responder with host-side read and write buffers
//
// Ports:
//   clk            bus clock, single clock domain
//   rst            asynchronous active-high reset
//   ft             FT bus (slave modport of ft600_responder_if)
//   host_wr_en     push {host_wr_be, host_wr_data} into the read buffer (toward master)
//   host_wr_data   [DATA_WIDTH] host push data
//   host_wr_be     [BE_WIDTH]   host push byte enables
//   host_full      read buffer full
//   host_rd_en     pop the write buffer (data from master)
//   host_rd_data   [DATA_WIDTH+BE_WIDTH] {be, data} of write buffer head, first-word-fall-through
//   host_rd_valid  write buffer not empty
//   rxf_hold       force ft_rxf_n high
//   txe_hold       force ft_txe_n high
//   proto_err      sticky protocol violation flag
//   err_code       cause of the first violation: 1 read without OE setup, 2 underrun,
//                  3 overrun or write during OE
module ft600_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 512,
  localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                         clk,
  input  logic                         rst,
  ft600_responder_if.slave             ft,
  input  logic                         host_wr_en,
  input  logic [DATA_WIDTH-1:0]        host_wr_data,
  input  logic [BE_WIDTH-1:0]          host_wr_be,
  output logic                         host_full,
  input  logic                         host_rd_en,
  output logic [DATA_WIDTH+BE_WIDTH-1:0] host_rd_data,
  output logic                         host_rd_valid,
  input  logic                         rxf_hold,
  input  logic                         txe_hold,
  output logic                         proto_err,
  output logic [1:0]                   err_code
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + BE_WIDTH;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OE_SETUP = 2'd1,
    READ     = 2'd2,
    WRITE    = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Read buffer: host -> master
  logic [EW-1:0] rmem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] rcnt;

  // Write buffer: master -> host
  logic [EW-1:0] wmem [DEPTH];
  logic [AW-1:0] w_wptr, w_rptr;
  logic [CW-1:0] wcnt;

  logic          rxf_n, txe_n;
  logic          bus_pop, bus_push;
  logic          host_push, host_pop;
  logic          viol;
  logic [1:0]    viol_code;
  logic          rd_phase;
  logic [EW-1:0] r_head;

  // Flags come only from registered counts plus the hold inputs, so the
  // master never sees a combinational path from its own strobes.
  assign rxf_n = (rcnt == '0) | rxf_hold;
  assign txe_n = (wcnt == FULL) | txe_hold;

  assign ft.ft_rxf_n   = rxf_n;
  assign ft.ft_txe_n   = txe_n;
  assign ft.ft_data_oe = !ft.ft_oe_n;

  // Head entry is presented continuously so data is valid the same cycle OE falls.
  assign r_head = (rcnt != '0) ? rmem[r_rptr] : '0;
  assign {ft.ft_be_o, ft.ft_data_o} = r_head;

  assign host_full     = (rcnt == FULL);
  assign host_rd_valid = (wcnt != '0);
  assign host_rd_data  = host_rd_valid ? wmem[w_rptr] : '0;

  assign host_push = host_wr_en & !host_full;
  assign host_pop  = host_rd_en & host_rd_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bus_pop   = 1'b0;
    bus_push  = 1'b0;
    viol      = 1'b0;
    viol_code = 2'd0;
    rd_phase  = (state == OE_SETUP) || (state == READ);

    case (state)
      IDLE: begin
        if (!ft.ft_oe_n) begin
          state_nxt = OE_SETUP;
        end else if (!ft.ft_wr_n) begin
          state_nxt = WRITE;
        end
      end
      OE_SETUP: begin
        if (ft.ft_oe_n) begin
          state_nxt = IDLE;
        end else if (!ft.ft_rd_n) begin
          state_nxt = READ;
        end
      end
      READ: begin
        if (ft.ft_oe_n) begin
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        if (ft.ft_wr_n) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A read strobe is only honoured once OE has been low for at least one
    // edge; an illegal strobe never touches the buffer.
    if (!ft.ft_rd_n) begin
      if (!rd_phase) begin
        viol      = 1'b1;
        viol_code = 2'd1;
      end else if (rxf_n) begin
        viol      = 1'b1;
        viol_code = 2'd2;
      end else if (!ft.ft_oe_n) begin
        bus_pop = 1'b1;
      end
    end

    if (!ft.ft_wr_n) begin
      if (txe_n || !ft.ft_oe_n) begin
        if (!viol) begin
          viol      = 1'b1;
          viol_code = 2'd3;
        end
      end else begin
        bus_push = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err <= 1'b0;
      err_code  <= 2'd0;
    end else if (viol && !proto_err) begin
      proto_err <= 1'b1;
      err_code  <= viol_code;
    end
  end

  // Buffer storage carries no reset; validity is governed by the counts.
  always_ff @(posedge clk) begin
    if (host_push) begin
      rmem[r_wptr] <= {host_wr_be, host_wr_data};
    end
    if (bus_push) begin
      wmem[w_wptr] <= {ft.ft_be_i, ft.ft_data_i};
    end
  end

  // Pointers are exactly AW bits wide, so wrap modulo DEPTH is implicit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      rcnt   <= '0;
    end else begin
      if (host_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (bus_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({host_push, bus_pop})
        2'b10:   rcnt <= rcnt + 1'b1;
        2'b01:   rcnt <= rcnt - 1'b1;
        default: rcnt <= rcnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_wptr <= '0;
      w_rptr <= '0;
      wcnt   <= '0;
    end else begin
      if (bus_push) begin
        w_wptr <= w_wptr + 1'b1;
      end
      if (host_pop) begin
        w_rptr <= w_rptr + 1'b1;
      end
      case ({bus_push, host_pop})
        2'b10:   wcnt <= wcnt + 1'b1;
        2'b01:   wcnt <= wcnt - 1'b1;
        default: wcnt <= wcnt;
      endcase
    end
  end

endmodule

// File: doc/ft600_responder.md
FT600_RESPONDER -- requirements
Module: ft600_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 16: FT bus data width in bits; BE_WIDTH = DATA_WIDTH/8.
REQ-002 Parameter DEPTH, default 512: entries per internal buffer; power of 2, at least 4.
REQ-003 clk  in  1  FT bus clock; all logic in this single domain.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ft_data_i  in  DATA_WIDTH  bus data driven by master (valid when ft_oe_n=1).
REQ-006 ft_data_o  out  DATA_WIDTH  bus data driven to master.
REQ-007 ft_data_oe  out  1  high = responder drives ft_data_o and ft_be_o.
REQ-008 ft_be_i / ft_be_o  in / out  BE_WIDTH  byte enables, master-driven / responder-driven.
REQ-009 ft_rxf_n  out  1  low = data available for master to read.
REQ-010 ft_txe_n  out  1  low = space available for master to write.
REQ-011 ft_rd_n, ft_wr_n, ft_oe_n  in  1 each  master strobes, active-low.
REQ-012 host_wr_en  in  1  push {host_wr_be, host_wr_data} into read buffer (toward master).
REQ-013 host_wr_data  in  DATA_WIDTH; host_wr_be  in  BE_WIDTH.
REQ-014 host_full  out  1  read buffer full.
REQ-015 host_rd_en  in  1  pop write buffer (from master); host_rd_data  out  DATA_WIDTH+BE_WIDTH  {be,data}, first-word-fall-through; host_rd_valid  out  1.
REQ-016 rxf_hold, txe_hold  in  1 each  force ft_rxf_n / ft_txe_n high (backpressure injection).
REQ-017 proto_err  out  1  sticky protocol violation; err_code  out  2  first violation cause.

Function
REQ-018 Read buffer: synchronous FIFO, DEPTH entries of DATA_WIDTH+BE_WIDTH bits, registered occupancy count rcnt (log2(DEPTH)+1 bits).
REQ-019 ft_rxf_n = (rcnt==0) | rxf_hold; ft_txe_n = (wcnt==DEPTH) | txe_hold; both decoded only from registered state and hold inputs.
REQ-020 ft_data_oe = !ft_oe_n; ft_data_o/ft_be_o = head entry of read buffer (zero when empty), valid same cycle ft_oe_n falls.
REQ-021 Bus pop: at clk edge with ft_rd_n=0, ft_oe_n=0, ft_rxf_n=0 -> head consumed; next head on ft_data_o the following cycle.
REQ-022 Bus push: at clk edge with ft_wr_n=0, ft_oe_n=1, ft_txe_n=0 -> {ft_be_i, ft_data_i} written to write buffer.
REQ-023 Host push accepted only when host_full=0; host pop accepted only when host_rd_valid=1; other requests ignored.
REQ-024 Simultaneous host push and bus pop on the read buffer: rcnt unchanged, both take effect; same for bus push and host pop on the write buffer.
REQ-025 Pointers wrap modulo DEPTH; rcnt/wcnt never exceed DEPTH nor go below 0.
REQ-026 Bus-phase FSM states: IDLE, OE_SETUP, READ, WRITE; IDLE->OE_SETUP on ft_oe_n=0; OE_SETUP->READ on ft_rd_n=0; READ->IDLE on ft_oe_n=1; IDLE->WRITE on ft_wr_n=0; WRITE->IDLE on ft_wr_n=1; OE_SETUP->IDLE on ft_oe_n=1.
REQ-027 Violations set proto_err and latch err_code on first occurrence only: 1 = ft_rd_n=0 in IDLE (no OE setup cycle); 2 = ft_rd_n=0 with ft_rxf_n=1 (underrun); 3 = ft_wr_n=0 with ft_txe_n=1 (overrun) or with ft_oe_n=0 (contention).
REQ-028 Violating strobes have no buffer effect (no pop on underrun, no push on overrun/contention).
REQ-029 err_code 0 when proto_err=0.

Reset
REQ-030 While rst=1: both buffers empty, FSM IDLE, ft_rxf_n=1, ft_txe_n=1 only if txe_hold else 0, ft_data_oe follows ft_oe_n, ft_data_o=0, host_rd_valid=0, host_full=0, proto_err=0, err_code=0.
REQ-031 Reset mid-transfer discards all buffered data; first post-reset bus pop returns first post-reset host push.

Verification
REQ-032 Host pushes 0x1111,0x2222,0x3333 (be=11); master OE one cycle then RD for 3 cycles -> master captures 1111,2222,3333; ft_rxf_n=1 cycle after third pop; proto_err=0.
REQ-033 Master writes 0xA5A5 be=01 then 0x5A5A be=11 -> host_rd_data=0x1A5A5 then 0x35A5A; host_rd_valid drops after second pop.
REQ-034 Master writes DEPTH words -> ft_txe_n=1 after last; extra write with wr_n=0 -> no push, proto_err=1, err_code=3.
REQ-035 ft_rd_n=0 asserted with ft_oe_n low the same cycle from IDLE -> proto_err=1, err_code=1, rcnt unchanged.
REQ-036 Buffer at DEPTH-1, simultaneous host push and bus pop for 10 cycles -> rcnt stays DEPTH-1, data order preserved across pointer wrap.
REQ-037 rst asserted mid-read with 5 words buffered -> ft_rxf_n=1 within same cycle, host_full=0, proto_err=0 after release.
